// File: rtl/cpu7_exu_bypctl.sv
// cpu7_exu_bypctl: E-stage operand bypass select, load-use / scoreboard / WAW
// stall generation, per-GPR scoreboard of outstanding long-latency writes and
// a saturating stall-cycle counter.
//
// Handshake semantics: iss_vld and lw_vld are plain valid qualifiers with no
// ready back-pressure. An issue "fires" in a cycle with iss_vld & ~stall_e.
// A long-latency writeback fires in every cycle with lw_vld; the consumer
// always accepts it. All other inputs are don't-care when their valid is low.
module cpu7_exu_bypctl #(
    parameter int NSRC = 2,
    parameter int NSTG = 2,
    parameter int CNTW = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NSRC*5-1:0]           rs_e,
    input  logic [NSRC-1:0]             rs_vld_e,
    input  logic [NSTG*5-1:0]           stg_rd,
    input  logic [NSTG-1:0]             stg_wen,
    input  logic [NSTG-1:0]             stg_rdy,
    input  logic                        iss_vld,
    input  logic [4:0]                  iss_rd,
    input  logic                        iss_long,
    input  logic                        lw_vld,
    input  logic [4:0]                  lw_rd,
    output logic [NSRC*(NSTG+2)-1:0]    byp_sel,
    output logic                        stall_e,
    output logic [31:0]                 sb_pend,
    output logic [CNTW-1:0]             stall_cnt
);

    // Select vector per operand: bit 0 = RF, bit 1+k = stage k, top bit = lw port.
    localparam int SELW = NSTG + 2;

    logic [NSRC-1:0] op_haz;
    logic            waw;
    logic            iss_fire;
    logic [31:0]     sb_next;

    // Per-operand source select and hazard; operands are evaluated independently.
    always_comb begin : operand_select
        logic [4:0]      rs;
        logic            hit;
        logic [SELW-1:0] sel;
        rs      = '0;
        hit     = 1'b0;
        sel     = '0;
        byp_sel = '0;
        op_haz  = '0;
        for (int i = 0; i < NSRC; i++) begin
            rs     = rs_e[5*i +: 5];
            hit    = 1'b0;
            sel    = '0;
            sel[0] = 1'b1;
            // r0 and non-GPR operands always read the RF path and never stall.
            if (rs_vld_e[i] && rs != 5'd0) begin
                // Stage 0 is youngest, so the first match wins.
                for (int k = 0; k < NSTG; k++) begin
                    if (!hit && stg_wen[k] && stg_rd[5*k +: 5] == rs) begin
                        hit        = 1'b1;
                        sel        = '0;
                        sel[1 + k] = 1'b1;
                        // Producer not ready yet (load in M): hold the select, stall.
                        if (!stg_rdy[k]) begin
                            op_haz[i] = 1'b1;
                        end
                    end
                end
                if (!hit) begin
                    if (lw_vld && lw_rd == rs) begin
                        sel            = '0;
                        sel[SELW - 1]  = 1'b1;
                    end else if (sb_pend[rs]) begin
                        op_haz[i] = 1'b1;
                    end
                end
            end
            byp_sel[SELW*i +: SELW] = sel;
        end
    end

    // A second long op to a pending register must wait unless the old write lands now.
    assign waw = iss_long && (iss_rd != 5'd0) && sb_pend[iss_rd]
                 && !(lw_vld && lw_rd == iss_rd);

    assign stall_e  = iss_vld && ((|op_haz) || waw);
    assign iss_fire = iss_vld && !stall_e;

    // Scoreboard next state: clear on writeback first, so a same-cycle set wins.
    always_comb begin
        sb_next = sb_pend;
        if (lw_vld) begin
            sb_next[lw_rd] = 1'b0;
        end
        if (iss_fire && iss_long) begin
            sb_next[iss_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard register; reset forgets every outstanding write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_pend <= '0;
        end else begin
            sb_pend <= sb_next;
        end
    end

    // Saturating count of cycles where a valid E-stage instruction is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (iss_vld && stall_e && stall_cnt != {CNTW{1'b1}}) begin
            stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cpu7_exu_bypctl.sv
// Bench for cpu7_exu_bypctl (NSRC=2, NSTG=2, CNTW=4): directed vectors, one
// per cycle, each carrying its hand-computed expected outputs into exp_q; a
// negedge monitor pops and compares byp_sel, stall_e, sb_pend and stall_cnt.
module tb_cpu7_exu_bypctl;

    localparam int NSRC = 2;
    localparam int NSTG = 2;
    localparam int CNTW = 4;
    localparam int SELW = NSTG + 2;
    localparam int EW   = NSRC*SELW + 1 + 32 + CNTW;

    localparam logic [3:0] RF = 4'b0001;
    localparam logic [3:0] S0 = 4'b0010;
    localparam logic [3:0] S1 = 4'b0100;
    localparam logic [3:0] LW = 4'b1000;

    logic                     clk;
    logic                     resetn;
    logic [NSRC*5-1:0]        rs_e;
    logic [NSRC-1:0]          rs_vld_e;
    logic [NSTG*5-1:0]        stg_rd;
    logic [NSTG-1:0]          stg_wen;
    logic [NSTG-1:0]          stg_rdy;
    logic                     iss_vld;
    logic [4:0]               iss_rd;
    logic                     iss_long;
    logic                     lw_vld;
    logic [4:0]               lw_rd;
    logic [NSRC*SELW-1:0]     byp_sel;
    logic                     stall_e;
    logic [31:0]              sb_pend;
    logic [CNTW-1:0]          stall_cnt;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;

    cpu7_exu_bypctl #(.NSRC(NSRC), .NSTG(NSTG), .CNTW(CNTW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rs_e      (rs_e),
        .rs_vld_e  (rs_vld_e),
        .stg_rd    (stg_rd),
        .stg_wen   (stg_wen),
        .stg_rdy   (stg_rdy),
        .iss_vld   (iss_vld),
        .iss_rd    (iss_rd),
        .iss_long  (iss_long),
        .lw_vld    (lw_vld),
        .lw_rd     (lw_rd),
        .byp_sel   (byp_sel),
        .stall_e   (stall_e),
        .sb_pend   (sb_pend),
        .stall_cnt (stall_cnt)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one vector just after the rising edge and queue its expectation.
    // With t_rst set, reset is pulled low mid-cycle, before the monitor samples.
    task automatic vec(input logic [9:0] t_rs, input logic [1:0] t_rsv,
                       input logic [9:0] t_srd, input logic [1:0] t_wen,
                       input logic [1:0] t_rdy, input logic t_iv,
                       input logic [4:0] t_ird, input logic t_il,
                       input logic t_lv, input logic [4:0] t_lrd,
                       input logic [7:0] e_sel, input logic e_st,
                       input logic [31:0] e_sb, input logic [3:0] e_cnt,
                       input logic t_rst);
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        rs_e     = t_rs;
        rs_vld_e = t_rsv;
        stg_rd   = t_srd;
        stg_wen  = t_wen;
        stg_rdy  = t_rdy;
        iss_vld  = t_iv;
        iss_rd   = t_ird;
        iss_long = t_il;
        lw_vld   = t_lv;
        lw_rd    = t_lrd;
        exp_q.push_back({e_sel, e_st, e_sb, e_cnt});
        if (t_rst) begin
            #1;
            resetn = 1'b0;
        end
    endtask

    // Monitor: compare every field of the presented response against the queue head.
    always @(negedge clk) begin
        logic [EW-1:0]    e;
        logic [7:0]       e_sel;
        logic             e_st;
        logic [31:0]      e_sb;
        logic [CNTW-1:0]  e_cnt;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            {e_sel, e_st, e_sb, e_cnt} = e;
            n_checks += 4;
            if (byp_sel !== e_sel) begin
                n_fail++;
                $display("FAIL byp_sel t=%0t got=%b exp=%b", $time, byp_sel, e_sel);
            end
            if (stall_e !== e_st) begin
                n_fail++;
                $display("FAIL stall_e t=%0t got=%b exp=%b", $time, stall_e, e_st);
            end
            if (sb_pend !== e_sb) begin
                n_fail++;
                $display("FAIL sb_pend t=%0t got=%h exp=%h", $time, sb_pend, e_sb);
            end
            if (stall_cnt !== e_cnt) begin
                n_fail++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e_cnt);
            end
        end
    end

    // Directed stimulus
    initial begin
        int wait_cyc;
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        rs_e     = '0;
        rs_vld_e = '0;
        stg_rd   = '0;
        stg_wen  = '0;
        stg_rdy  = '0;
        iss_vld  = 1'b0;
        iss_rd   = '0;
        iss_long = 1'b0;
        lw_vld   = 1'b0;
        lw_rd    = '0;
        repeat (3) @(posedge clk);

        // Reset state, idle inputs
        vec('0, 2'b00, '0, 2'b00, 2'b00, 0, 5'd0, 0, 0, 5'd0, {RF, RF}, 0, 32'h0, 4'd0, 0);
        // Priority: both stages write r3 -> youngest (stage0)
        vec({5'd3, 5'd3}, 2'b11, {5'd3, 5'd3}, 2'b11, 2'b11, 1, 5'd0, 0, 0, 5'd0, {S0, S0}, 0, 32'h0, 4'd0, 0);
        // Stage0 not writing -> stage1
        vec({5'd3, 5'd3}, 2'b11, {5'd3, 5'd3}, 2'b10, 2'b11, 1, 5'd0, 0, 0, 5'd0, {S1, S1}, 0, 32'h0, 4'd0, 0);
        // r0 operand with stage1 writing r0; op1=r5 not a GPR with stage0 writing r5
        vec({5'd5, 5'd0}, 2'b01, {5'd0, 5'd5}, 2'b11, 2'b11, 1, 5'd0, 0, 0, 5'd0, {RF, RF}, 0, 32'h0, 4'd0, 0);
        // Load-use on r7 in stage0, twice
        vec({5'd0, 5'd7}, 2'b01, {5'd0, 5'd7}, 2'b01, 2'b00, 1, 5'd0, 0, 0, 5'd0, {RF, S0}, 1, 32'h0, 4'd0, 0);
        vec({5'd0, 5'd7}, 2'b01, {5'd0, 5'd7}, 2'b01, 2'b00, 1, 5'd0, 0, 0, 5'd0, {RF, S0}, 1, 32'h0, 4'd1, 0);
        // Same hazard with no valid instruction: no stall, no count
        vec({5'd0, 5'd7}, 2'b01, {5'd0, 5'd7}, 2'b01, 2'b00, 0, 5'd0, 0, 0, 5'd0, {RF, S0}, 0, 32'h0, 4'd2, 0);
        // Independence: op0 load-use on stage0, op1 clean forward from stage1
        vec({5'd8, 5'd7}, 2'b11, {5'd8, 5'd7}, 2'b11, 2'b10, 1, 5'd0, 0, 0, 5'd0, {S1, S0}, 1, 32'h0, 4'd2, 0);
        // Scoreboard round trip on r9
        vec('0, 2'b00, '0, 2'b00, 2'b00, 1, 5'd9, 1, 0, 5'd0, {RF, RF}, 0, 32'h0, 4'd3, 0);
        vec({5'd0, 5'd9}, 2'b01, '0, 2'b00, 2'b00, 1, 5'd0, 0, 0, 5'd0, {RF, RF}, 1, 32'h200, 4'd3, 0);
        vec({5'd0, 5'd9}, 2'b01, '0, 2'b00, 2'b00, 1, 5'd0, 0, 1, 5'd9, {RF, LW}, 0, 32'h200, 4'd4, 0);
        vec({5'd0, 5'd9}, 2'b01, '0, 2'b00, 2'b00, 1, 5'd0, 0, 0, 5'd0, {RF, RF}, 0, 32'h0, 4'd4, 0);
        // Long issue r4, then same-cycle clear+set of r4 (set wins)
        vec('0, 2'b00, '0, 2'b00, 2'b00, 1, 5'd4, 1, 0, 5'd0, {RF, RF}, 0, 32'h0, 4'd4, 0);
        vec('0, 2'b00, '0, 2'b00, 2'b00, 1, 5'd4, 1, 1, 5'd4, {RF, RF}, 0, 32'h10, 4'd4, 0);
        // WAW: second long issue to pending r4 without a writeback
        vec('0, 2'b00, '0, 2'b00, 2'b00, 1, 5'd4, 1, 0, 5'd0, {RF, RF}, 1, 32'h10, 4'd4, 0);
        // Writeback to a register that is not pending is ignored
        vec('0, 2'b00, '0, 2'b00, 2'b00, 0, 5'd0, 0, 1, 5'd11, {RF, RF}, 0, 32'h10, 4'd5, 0);
        // Clear r4 while setting r12
        vec('0, 2'b00, '0, 2'b00, 2'b00, 1, 5'd12, 1, 1, 5'd4, {RF, RF}, 0, 32'h10, 4'd5, 0);
        vec('0, 2'b00, '0, 2'b00, 2'b00, 0, 5'd0, 0, 0, 5'd0, {RF, RF}, 0, 32'h1000, 4'd5, 0);
        // Drive the counter into saturation at 4'hF and hold
        for (int n = 0; n < 13; n++) begin
            vec({5'd0, 5'd7}, 2'b01, {5'd0, 5'd7}, 2'b01, 2'b00, 1, 5'd0, 0, 0, 5'd0,
                {RF, S0}, 1, 32'h1000, ((5 + n) > 15) ? 4'd15 : 4'(5 + n), 0);
        end
        // Async reset mid-cycle: state clears at once, select still follows inputs
        vec({5'd0, 5'd3}, 2'b01, {5'd0, 5'd3}, 2'b01, 2'b01, 0, 5'd0, 0, 0, 5'd0, {RF, S0}, 0, 32'h0, 4'd0, 1);
        // Stale writeback for r12 after reset clears nothing; consumer of r12 is clean
        vec({5'd0, 5'd12}, 2'b01, '0, 2'b00, 2'b00, 0, 5'd0, 0, 1, 5'd12, {RF, LW}, 0, 32'h0, 4'd0, 0);
        vec({5'd0, 5'd12}, 2'b01, '0, 2'b00, 2'b00, 1, 5'd0, 0, 0, 5'd0, {RF, RF}, 0, 32'h0, 4'd0, 0);

        // Drain the scoreboard queue with a bounded wait
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
